// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op and state encodings for the multiply/divide unit
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // op[1] selects divide, op[0] selects the unsigned flavour
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - operand magnitude conversion and result sign correction
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg_res,
  output logic               neg_rem,
  input  logic               is_div,
  input  logic               fix_res,
  input  logic               fix_rem,
  input  logic [2*WIDTH-1:0] res,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic               sa;
  logic               sb;
  logic [2*WIDTH-1:0] prod;

  // entry side: strip signs so the iterations only ever see magnitudes
  always_comb begin
    sa      = is_signed & a[WIDTH-1];
    sb      = is_signed & b[WIDTH-1];
    mag_a   = sa ? -a : a;
    mag_b   = sb ? -b : b;
    neg_res = sa ^ sb;
    neg_rem = sa;
  end

  // exit side: product negated as a whole, quotient and remainder independently
  always_comb begin
    prod = fix_res ? -res : res;
    if (is_div) begin
      lo = fix_res ? -res[WIDTH-1:0] : res[WIDTH-1:0];
      hi = fix_rem ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH];
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with start/busy/done handshake
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state;
  md_state_e          state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;        // upper: partial product/remainder, lower: multiplier/quotient
  logic [WIDTH-1:0]   opb;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dvd;        // raw dividend, returned on divide by zero
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div_zero_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_iter;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_signed (op_is_signed(op)),
    .a         (num1),
    .b         (num2),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_res   (neg_res),
    .neg_rem   (neg_rem),
    .is_div    (is_div_q),
    .fix_res   (neg_res_q),
    .fix_rem   (neg_rem_q),
    .res       (acc),
    .hi        (fix_hi),
    .lo        (fix_lo)
  );

  // iteration WIDTH is the extra cycle that sign-corrects and publishes hi/lo
  assign last_iter = (cnt == CNT_W'(WIDTH));

  // one iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    if (!is_div_q) begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // state register with busy/done registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != MD_IDLE);
      done  <= (state_nxt == MD_DONE);
    end
  end

  // next state; cancel wins over start and aborts CALC/DONE
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start && !cancel) state_nxt = MD_CALC;
      MD_CALC: begin
        if (cancel)         state_nxt = MD_IDLE;
        else if (last_iter) state_nxt = MD_DONE;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      dvd        <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          cnt <= '0;
          if (start && !cancel) begin
            acc        <= {{WIDTH{1'b0}}, mag_a};
            opb        <= mag_b;
            dvd        <= num1;
            is_div_q   <= op_is_div(op);
            neg_res_q  <= neg_res;
            neg_rem_q  <= neg_rem;
            div_zero_q <= op_is_div(op) && (num2 == '0);
          end
        end
        MD_CALC: begin
          if (!cancel) begin
            if (last_iter) begin
              hi <= div_zero_q ? dvd : fix_hi;
              lo <= div_zero_q ? {WIDTH{1'b1}} : fix_lo;
            end else begin
              acc <= acc_step;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last = '0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .num1   (num1),
    .num2   (num2),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {hi, lo} straight from the architectural definition of each op
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    int          q;
    int          r;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      MD_MULT: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      MD_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        return up;
      end
      MD_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
    return $urandom;
  endfunction

  // start sampled on edge 0; operands scrambled right after to prove they are latched
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; num1 = a; num2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); num1 = $urandom; num2 = $urandom;
  endtask

  // watch edges 1..ncyc; optional stray start pulses sampled at edges e1/e2
  task automatic wait_done(input int e1, input int e2, input bit stop, input int ncyc,
                           output int lat, output int nd, output logic [31:0] h, output logic [31:0] l);
    lat = -1; nd = 0; h = '0; l = '0;
    for (int k = 1; k <= ncyc; k++) begin
      start = (k == e1 || k == e2);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = k; h = hi; l = lo;
          if (stop) break;
        end
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int lat, nd;
    logic [31:0] h, l;
    issue(o, a, b);
    wait_done(0, 0, 1'b1, 40, lat, nd, h, l);
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " hi"}, {32'h0, h}, {32'h0, exp[63:32]});
    check({tag, " lo"}, {32'h0, l}, {32'h0, exp[31:0]});
    last = exp;
  endtask

  initial begin
    int lat, nd;
    logic [31:0] h, l;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    check("reset hi/lo", {hi, lo}, 64'h0);
    rst = 1'b0;

    // directed vectors; consecutive calls also exercise back-to-back starts
    run_vec("mult -1*2", MD_MULT, 32'hFFFF_FFFF, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_vec("multu ffffffff*2", MD_MULTU, 32'hFFFF_FFFF, 32'h2, {32'h1, 32'hFFFF_FFFE});
    run_vec("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_vec("divu ffffffff/16", MD_DIVU, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF});
    run_vec("div overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_vec("divu by zero", MD_DIVU, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF});

    // stray starts while busy are ignored
    issue(MD_MULTU, 32'd7, 32'd9);
    wait_done(5, 32, 1'b0, 45, lat, nd, h, l);
    check("busy start latency", 64'(lat), 64'd33);
    check("busy start done count", 64'(nd), 64'd1);
    check("busy start lo", {32'h0, l}, 64'd63);
    last = 64'd63;

    // cancel sampled at edge 10 of a MULT
    issue(MD_MULT, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    check("busy before cancel", {63'h0, busy}, 64'h1);
    cancel = 1'b1;
    @(posedge clk); @(negedge clk);
    cancel = 1'b0;
    check("busy after cancel", {63'h0, busy}, 64'h0);
    wait_done(0, 0, 1'b0, 40, lat, nd, h, l);
    check("cancel done count", 64'(nd), 64'd0);
    check("cancel hi/lo kept", {hi, lo}, last);

    // start together with cancel in IDLE
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = MD_MULTU; num1 = 32'd3; num2 = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("start+cancel busy", {63'h0, busy}, 64'h0);
    wait_done(0, 0, 1'b0, 40, lat, nd, h, l);
    check("start+cancel done count", 64'(nd), 64'd0);

    // cancel during DONE leaves the published result alone
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(0, 0, 1'b1, 40, lat, nd, h, l);
    cancel = 1'b1;
    check("done-cancel done", {63'h0, done}, 64'h1);
    check("done-cancel hi/lo", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    cancel = 1'b0;
    check("done-cancel busy", {63'h0, busy}, 64'h0);
    check("done-cancel hi/lo held", {hi, lo}, {32'd2, 32'd14});

    // asynchronous reset mid-CALC
    issue(MD_MULT, 32'h1234, 32'h5678);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", {63'h0, busy}, 64'h0);
    check("async rst done", {63'h0, done}, 64'h0);
    check("async rst hi/lo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec("multu 3*5", MD_MULTU, 32'd3, 32'd5, {32'h0, 32'd15});

    // randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_vec($sformatf("rand%0d op%0d %h,%h", i, ro, ra, rb), ro, ra, rb, model(ro, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the MIPS execute stage. It sits beside the combinational ALU and produces the HI/LO results for MULT, MULTU, DIV and DIVU.
- Takes a fixed WIDTH+1 cycles per operation.
- Uses a start/busy/done handshake so the pipeline can stall on busy.
- Accepts a cancel input that aborts the operation on exception flush.
- WIDTH is parametrised; the default is the 32-bit datapath.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
num1  input  WIDTH  multiplicand or dividend (rs).
num2  input  WIDTH  multiplier or divisor (rt).
cancel  input  1  abort the current operation (exception flush).
busy  output  1  high while an operation is in flight (CALC or DONE).
done  output  1  one-cycle pulse; hi/lo are valid in that cycle.
hi  output  WIDTH  product upper half, or remainder.
lo  output  WIDTH  product lower half, or quotient.

Behaviour:
- Reset: asynchronous on rst high, whatever the state.
  - state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
  - An operation in progress when reset arrives is discarded.
- States:
  - IDLE -> CALC on start && !cancel. Operands and op are latched on that edge; later changes to num1/num2/op are ignored.
  - CALC: one iteration per cycle for exactly WIDTH cycles, then -> DONE.
  - DONE: done=1 for one cycle, hi/lo updated on entry, then -> IDLE.
- Latency: if start is sampled at edge 0, done is high in the cycle after edge WIDTH+1. That is WIDTH+1 cycles; 33 for the default.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.
- busy is registered; it is high from the edge after start through the DONE cycle.
- Start handling:
  - start while busy is ignored; no queuing.
  - start and cancel in the same cycle: cancel wins and nothing starts.
- Cancel:
  - Returns to IDLE on the next edge from CALC or DONE.
  - A cancel in the DONE cycle suppresses nothing already visible: hi/lo were written on DONE entry and done is already asserted.
  - A cancel in CALC leaves hi/lo at their previous values and produces no done.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitude before the iterations.
  - The product is negated iff the operand signs differ.
  - The quotient is negated iff the operand signs differ.
  - The remainder takes the sign of the dividend.
- Multiply: radix-2 shift-add over a 2*WIDTH accumulator; hi=acc[2W-1:W], lo=acc[W-1:0].
- Divide: restoring, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- Divide by zero (num2==0, signed or unsigned): defined result lo={WIDTH{1'b1}}, hi=num1 (raw dividend). Latency and done are unchanged.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0, with no trap.
- Arithmetic wraps modulo 2^WIDTH; there is no overflow flag.
- hi/lo hold their values until the next DONE or reset.

Decomposition:
- Shared defines header gets:
  - the op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - the state encodings MD_IDLE, MD_CALC, MD_DONE.
- One sub-module is natural: muldiv_sign_fix. It is combinational, parametrised by WIDTH, and does:
  - magnitude conversion of the operands on entry;
  - result sign correction on exit.
- The FSM, counter and the shared shift/accumulate register stay in muldiv_unit.

Test Plan:
- MULT with num1=0xFFFFFFFF, num2=0x00000002 -> done at cycle 33: hi=0xFFFFFFFF, lo=0xFFFFFFFE. The same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV with num1=0xFFFFFFF9 (-7), num2=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with num1=0xFFFFFFFF, num2=0x10 -> lo=0x0FFFFFFF, hi=0x0000000F.
- Boundary values:
  - DIV with num1=0x80000000, num2=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU with num1=0x12345678, num2=0 -> lo=0xFFFFFFFF, hi=0x12345678; done still arrives at cycle 33.
- Start handling:
  - start pulsed again at cycles 5 and 32 while busy -> ignored, exactly one done.
  - Back-to-back start on the first IDLE cycle after done -> second done 33 cycles later.
- Cancel at cycle 10 of a MULT -> busy drops on the next edge, no done, hi/lo keep prior values. start together with cancel in IDLE -> nothing starts.
- rst asserted asynchronously (off clock edge) mid-CALC -> busy, done, hi and lo go to 0 immediately. After release, a fresh MULTU 3*5 -> lo=15, hi=0.
